// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode seven-segment scan driver.
// A 16-bit hex word is loaded through a strobe into a pending register. It is
// committed to the displayed copy only at a frame wrap, so one frame never
// mixes old and new digits. The active digit advances once per refresh tick.
// Anode, cathode and decimal-point outputs are registered from the current
// digit index and the displayed copy.
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_mask,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        upd_ack
);

  localparam int               PRE_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] hex_font(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'b1000000;
      4'h1:    pat = 7'b1111001;
      4'h2:    pat = 7'b0100100;
      4'h3:    pat = 7'b0110000;
      4'h4:    pat = 7'b0011001;
      4'h5:    pat = 7'b0010010;
      4'h6:    pat = 7'b0000010;
      4'h7:    pat = 7'b1111000;
      4'h8:    pat = 7'b0000000;
      4'h9:    pat = 7'b0010000;
      4'hA:    pat = 7'b0001000;
      4'hB:    pat = 7'b0000011;
      4'hC:    pat = 7'b1000110;
      4'hD:    pat = 7'b0100001;
      4'hE:    pat = 7'b0000110;
      default: pat = 7'b0001110;
    endcase
    return pat;
  endfunction

  // Per-digit blanking flags. A digit is a leading zero when it and every
  // more-significant nibble are zero. A lit decimal point keeps the digit
  // visible, and digit 0 always shows so that a zero value still reads "0".
  function automatic logic [3:0] blank_vec(input logic [15:0] v,
                                           input logic [3:0]  m,
                                           input logic        b);
    logic [3:0] bv;
    bv[0] = 1'b0;
    bv[1] = b && (v[15:4]  == 12'h000) && !m[1];
    bv[2] = b && (v[15:8]  == 8'h00)   && !m[2];
    bv[3] = b && (v[15:12] == 4'h0)    && !m[3];
    return bv;
  endfunction

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;
  logic [1:0]       idx;
  logic             commit;

  logic [15:0]      pend_value;
  logic [3:0]       pend_dp;
  logic             pend_blank;
  logic             pend_vld;

  logic [15:0]      shown_value;
  logic [3:0]       shown_dp;
  logic             shown_blank;

  logic [3:0]       nib_p0;
  logic [3:0]       blank_p0;
  logic             vis_p0;
  logic [3:0]       an_p0;
  logic [6:0]       seg_p0;
  logic             dp_p0;

  assign tick   = (pre_cnt == PRE_LAST);
  assign commit = tick && (idx == 2'd3) && pend_vld;

  // Prescaler and digit index: one digit slot per REFRESH_DIV cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
      idx     <= 2'd0;
    end else if (tick) begin
      pre_cnt <= '0;
      idx     <= idx + 2'd1;
    end else begin
      pre_cnt <= pre_cnt + PRE_ONE;
    end
  end

  // Pending payload: the latest load wins. It is only meaningful while pend_vld is set.
  always_ff @(posedge clk) begin
    if (load) begin
      pend_value <= value;
      pend_dp    <= dp_mask;
      pend_blank <= blank_lz;
    end
  end

  // Pending flag. A load on the commit edge re-arms the flag for the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_vld <= 1'b0;
    end else if (load) begin
      pend_vld <= 1'b1;
    end else if (commit) begin
      pend_vld <= 1'b0;
    end
  end

  // Displayed copy: updated only at the frame wrap, and upd_ack is pulsed alongside.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shown_value <= 16'h0000;
      shown_dp    <= 4'h0;
      shown_blank <= 1'b0;
      upd_ack     <= 1'b0;
    end else begin
      upd_ack <= commit;
      if (commit) begin
        shown_value <= pend_value;
        shown_dp    <= pend_dp;
        shown_blank <= pend_blank;
      end
    end
  end

  // Stage 0: decode the active slot from idx and the displayed copy.
  always_comb begin
    nib_p0   = 4'h0;
    blank_p0 = blank_vec(shown_value, shown_dp, shown_blank);
    case (idx)
      2'd0:    nib_p0 = shown_value[3:0];
      2'd1:    nib_p0 = shown_value[7:4];
      2'd2:    nib_p0 = shown_value[11:8];
      default: nib_p0 = shown_value[15:12];
    endcase
    vis_p0 = !blank_p0[idx];
    an_p0  = 4'b1111;
    seg_p0 = 7'b1111111;
    dp_p0  = 1'b1;
    if (vis_p0) begin
      an_p0  = ~(4'b0001 << idx);
      seg_p0 = hex_font(nib_p0);
      dp_p0  = ~shown_dp[idx];
    end
  end

  // Stage 1: registered pin drivers, all dark during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else begin
      an  <= an_p0;
      seg <= seg_p0;
      dp  <= dp_p0;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with a short refresh divider.
module tb_seg7_scan_driver;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0000;
  logic [3:0]  dp_mask = 4'h0;
  logic        blank_lz = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        upd_ack;

  int total = 0;
  int bad   = 0;

  // Active-low font constants used by the expectation tables.
  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S7 = 7'b1111000, SA = 7'b0001000,
                         SB = 7'b0000011, SC = 7'b1000110, SD = 7'b0100001,
                         SE = 7'b0000110, SF = 7'b0001110, OFF = 7'b1111111;

  seg7_scan_driver #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp_mask(dp_mask),
    .blank_lz(blank_lz), .an(an), .seg(seg), .dp(dp), .upd_ack(upd_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive load inputs before the edge, return at the following negedge.
  task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] m, input logic b);
    load = ld; value = v; dp_mask = m; blank_lz = b;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
  endtask

  // One 16-cycle frame, aligned to reset release. segs = {d3,d2,d1,d0},
  // vis = visible digits, dps = expected dp pin per digit, ack_at = slot of upd_ack.
  // Up to two loads (at slot lda / ldb) are issued during the frame.
  task automatic frame(input string nm, input logic [27:0] segs, input logic [3:0] vis,
                       input logic [3:0] dps, input int ack_at,
                       input int lda, input logic [15:0] va,
                       input int ldb, input logic [15:0] vb,
                       input logic [3:0] m, input logic b);
    for (int n = 0; n < 16; n++) begin
      int d;
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic       e_dp;
      d = n / DIV;
      if (n == lda)      step(1'b1, va, m, b);
      else if (n == ldb) step(1'b1, vb, m, b);
      else               step(1'b0, 16'h0000, 4'h0, 1'b0);
      e_an  = vis[d] ? ~(4'b0001 << d) : 4'b1111;
      e_seg = vis[d] ? segs[7*d +: 7] : OFF;
      e_dp  = vis[d] ? dps[d] : 1'b1;
      chk($sformatf("%s.an[%0d]", nm, n),  {28'h0, an},  {28'h0, e_an});
      chk($sformatf("%s.seg[%0d]", nm, n), {25'h0, seg}, {25'h0, e_seg});
      chk($sformatf("%s.dp[%0d]", nm, n),  {31'h0, dp},  {31'h0, e_dp});
      chk($sformatf("%s.ack[%0d]", nm, n), {31'h0, upd_ack}, {31'h0, (n == ack_at)});
    end
  endtask

  initial begin
    // Reset held across several edges: all outputs dark.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.an",  {28'h0, an},  32'hF);
    chk("rst.seg", {25'h0, seg}, 32'h7F);
    chk("rst.dp",  {31'h0, dp},  32'h1);
    chk("rst.ack", {31'h0, upd_ack}, 32'h0);
    rst = 1'b0;

    // First frame after reset shows "0000"; 12AF is loaded in its first slot.
    frame("f1_zero", {S0, S0, S0, S0}, 4'b1111, 4'b1111, 15,
          0, 16'h12AF, -1, 16'h0, 4'h0, 1'b0);
    frame("f2_12af", {S1, S2, SA, SF}, 4'b1111, 4'b1111, -1,
          -1, 16'h0, -1, 16'h0, 4'h0, 1'b0);
    frame("f3_rep", {S1, S2, SA, SF}, 4'b1111, 4'b1111, 15,
          3, 16'h0005, -1, 16'h0, 4'h0, 1'b1);
    // Leading-zero blanking: only digit 0 lit.
    frame("f4_0005", {OFF, OFF, OFF, S5}, 4'b0001, 4'b1111, 15,
          7, 16'h0000, -1, 16'h0, 4'h0, 1'b1);
    frame("f5_0000", {OFF, OFF, OFF, S0}, 4'b0001, 4'b1111, 15,
          2, 16'h1111, 9, 16'h2222, 4'h0, 1'b0);
    // Two loads in one frame: only the latest is shown.
    frame("f6_2222", {S2, S2, S2, S2}, 4'b1111, 4'b1111, 15,
          5, 16'h0007, -1, 16'h0, 4'b0100, 1'b1);
    // A lit dp keeps digit 2 visible between blanked digits 1 and 3.
    frame("f7_dp", {OFF, S0, OFF, S7}, 4'b0101, 4'b1011, 15,
          0, 16'h3456, 15, 16'hBCDE, 4'h0, 1'b0);
    // The load on the commit edge is deferred by one frame.
    frame("f8_3456", {S3, S4, S5, S6}, 4'b1111, 4'b1111, 15,
          -1, 16'h0, -1, 16'h0, 4'h0, 1'b0);
    frame("f9_bcde", {SB, SC, SD, SE}, 4'b1111, 4'b1111, -1,
          -1, 16'h0, -1, 16'h0, 4'h0, 1'b0);

    // Mid-frame reset with a load pending.
    step(1'b1, 16'h89AB, 4'hF, 1'b0);
    repeat (4) step(1'b0, 16'h0000, 4'h0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst.an",  {28'h0, an},  32'hF);
    chk("mid_rst.seg", {25'h0, seg}, 32'h7F);
    chk("mid_rst.dp",  {31'h0, dp},  32'h1);
    chk("mid_rst.ack", {31'h0, upd_ack}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_hold.an", {28'h0, an}, 32'hF);
    rst = 1'b0;
    frame("r1_zero", {S0, S0, S0, S0}, 4'b1111, 4'b1111, -1,
          -1, 16'h0, -1, 16'h0, 4'h0, 1'b0);
    frame("r2_zero", {S0, S0, S0, S0}, 4'b1111, 4'b1111, -1,
          -1, 16'h0, -1, 16'h0, 4'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
